lane_sensor_decoder: RTL

- Upstream front-end for the parking occupancy FSM.
- Watches the two induction-loop sensors of a single bidirectional gate lane: outer, at the street side, and inner, at the lot side.
- Synchronises and debounces both sensors, then tracks the car's passage direction.
- Emits single-cycle enter/exit pulses that drive the occupancy FSM's enter/exit inputs directly.

---
 rtl/parking_pkg.sv | 21 ++
 rtl/sensor_debounce.sv | 40 ++++
 rtl/lane_sensor_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types for the parking lane front-end: passage-tracking states and
// the {outer, inner} filtered sensor pair encoding.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENT_1,
    ENT_2,
    ENT_3,
    EXT_1,
    EXT_2,
    EXT_3,
    ABORT
  } lane_state_t;

  localparam logic [1:0] SNS_NONE  = 2'b00;
  localparam logic [1:0] SNS_INNER = 2'b01;
  localparam logic [1:0] SNS_OUTER = 2'b10;
  localparam logic [1:0] SNS_BOTH  = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a run-length debounce filter for one
// induction-loop sensor.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic sens,
  output logic filt
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // The counter measures how long sync_2 has disagreed with filt.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      filt   <= 1'b0;
    end else begin
      sync_1 <= sens;
      sync_2 <= sync_1;
      if (sync_2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync_2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lane_sensor_decoder.sv
// Gate-lane front-end: debounces both loop sensors and tracks the passage
// direction, pulsing enter/exit on completed passages and err on aborts.
module lane_sensor_decoder
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic sens_outer,
  input  logic sens_inner,
  output logic enter,
  output logic exit,
  output logic busy,
  output logic err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic             o;
  logic             i;
  logic [1:0]       sns;
  lane_state_t      state_q;
  lane_state_t      state_d;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tracking;
  logic             enter_d;
  logic             exit_d;
  logic             err_d;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_outer (
    .CLK  (CLK),
    .RST  (RST),
    .sens (sens_outer),
    .filt (o)
  );

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_inner (
    .CLK  (CLK),
    .RST  (RST),
    .sens (sens_inner),
    .filt (i)
  );

  assign sns      = {o, i};
  assign tracking = (state_q != IDLE) && (state_q != ABORT);
  assign busy     = (state_q != IDLE);

  // Next state: the passage must walk the outer/both/inner ladder in order.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        case (sns)
          SNS_OUTER: state_d = ENT_1;
          SNS_INNER: state_d = EXT_1;
          SNS_BOTH:  state_d = ABORT;
          default:   ;
        endcase
      end
      ENT_1: begin
        case (sns)
          SNS_BOTH:  state_d = ENT_2;
          SNS_NONE:  state_d = IDLE;
          SNS_INNER: state_d = ABORT;
          default:   ;
        endcase
      end
      ENT_2: begin
        case (sns)
          SNS_INNER: state_d = ENT_3;
          SNS_OUTER: state_d = ENT_1;
          SNS_NONE:  state_d = ABORT;
          default:   ;
        endcase
      end
      ENT_3: begin
        case (sns)
          SNS_NONE:  state_d = IDLE;
          SNS_BOTH:  state_d = ENT_2;
          SNS_OUTER: state_d = ABORT;
          default:   ;
        endcase
      end
      EXT_1: begin
        case (sns)
          SNS_BOTH:  state_d = EXT_2;
          SNS_NONE:  state_d = IDLE;
          SNS_OUTER: state_d = ABORT;
          default:   ;
        endcase
      end
      EXT_2: begin
        case (sns)
          SNS_OUTER: state_d = EXT_3;
          SNS_INNER: state_d = EXT_1;
          SNS_NONE:  state_d = ABORT;
          default:   ;
        endcase
      end
      EXT_3: begin
        case (sns)
          SNS_NONE:  state_d = IDLE;
          SNS_BOTH:  state_d = EXT_2;
          SNS_INNER: state_d = ABORT;
          default:   ;
        endcase
      end
      ABORT: begin
        if (sns == SNS_NONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A stalled passage is abandoned even if the sensors moved this cycle.
    if (tracking && (tmo_cnt == TMO_LAST)) state_d = ABORT;
  end

  assign enter_d = (state_q == ENT_3) && (state_d == IDLE);
  assign exit_d  = (state_q == EXT_3) && (state_d == IDLE);
  assign err_d   = (state_d == ABORT) && (state_q != ABORT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      tmo_cnt <= '0;
      enter   <= 1'b0;
      exit    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      enter   <= enter_d;
      exit    <= exit_d;
      err     <= err_d;
      if ((state_d != state_q) || !tracking) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LAST) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

endmodule
